// File: rtl/int_ctrl_pkg.sv
// ============================================================================
// Module  : int_ctrl_pkg
// Brief   : Shared types and constants for the int_ctrl interrupt controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ_INT = 2'd1,
        ST_REQ_NMI = 2'd2,
        ST_GAP     = 2'd3
    } state_e;

    localparam logic [5:0]  NMI_VEC      = 6'd62;
    localparam logic [5:0]  RESET_VEC    = 6'd63;
    localparam logic [15:0] IE_ADDR_DEF  = 16'h0000;
    localparam logic [15:0] IFG_ADDR_DEF = 16'h0002;
    localparam int          IDX_W        = 4;

endpackage

`default_nettype wire

// File: rtl/int_prio_enc.sv
// ============================================================================
// Module  : int_prio_enc
// Brief   : N-input priority encoder; highest set bit wins, with valid flag.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0]     req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i]) begin
                idx_o   = IDX_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module  : int_ctrl
// Brief   : Edge-latched, maskable + NMI interrupt controller with IE/IFG
//           registers on the CPU bus. Optional input synchronizers are
//           enabled by defining INT_CTRL_SYNC_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int          N_SRC    = 8,
    parameter int          BASE_VEC = 48,
    parameter logic [15:0] IE_ADDR  = IE_ADDR_DEF,
    parameter logic [15:0] IFG_ADDR = IFG_ADDR_DEF
) (
    input  logic             MCLK,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic             nmi_in,
    input  logic [15:0]      MAB,
    input  logic [15:0]      MDBout,
    input  logic             MW,
    input  logic             BW,
    input  logic             INTACK,
    output logic             NMI,
    output logic             INT,
    output logic [5:0]       IntAddrLSBs,
    output logic [15:0]      rdata
);

    logic [N_SRC-1:0] w_irq_s;
    logic             w_nmi_s;

`ifdef INT_CTRL_SYNC_EN
    logic [N_SRC-1:0] irq_s1_q, irq_s2_q;
    logic             nmi_s1_q, nmi_s2_q;

    // Reset to ones so lines already high at reset do not look like edges.
    always_ff @(posedge MCLK) begin
        if (reset) begin
            irq_s1_q <= '1;
            irq_s2_q <= '1;
            nmi_s1_q <= 1'b1;
            nmi_s2_q <= 1'b1;
        end else begin
            irq_s1_q <= irq_in;
            irq_s2_q <= irq_s1_q;
            nmi_s1_q <= nmi_in;
            nmi_s2_q <= nmi_s1_q;
        end
    end

    assign w_irq_s = irq_s2_q;
    assign w_nmi_s = nmi_s2_q;
`else
    assign w_irq_s = irq_in;
    assign w_nmi_s = nmi_in;
`endif

    state_e           state_q, state_d;
    logic [5:0]       vec_q, vec_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N_SRC-1:0] ie_q, ie_d;
    logic [N_SRC-1:0] ifg_q, ifg_d;
    logic [N_SRC-1:0] irq_prev_q;
    logic             nmi_prev_q;
    logic             nmi_pend_q, nmi_pend_d;

    logic [N_SRC-1:0] w_irq_edge;
    logic             w_nmi_edge;
    logic             w_wr_word, w_wr_byte;
    logic [1:0]       w_ie_we, w_ifg_we;
    logic [N_SRC-1:0] w_sel, w_ack_clr;
    logic             w_ack_int, w_ack_nmi, w_sel_ie;
    logic [IDX_W-1:0] w_win_idx;
    logic             w_win_vld;

    assign w_irq_edge = w_irq_s & ~irq_prev_q;
    assign w_nmi_edge = w_nmi_s & ~nmi_prev_q;

    assign w_wr_word = MW & ~BW;
    assign w_wr_byte = MW & BW;

    // Byte lanes: lane 0 is the low byte at addr, lane 1 the high byte at addr+1.
    assign w_ie_we[0]  = (w_wr_word & (MAB == IE_ADDR)) |
                         (w_wr_byte & (MAB[15:1] == IE_ADDR[15:1]) & ~MAB[0]);
    assign w_ie_we[1]  = (w_wr_word & (MAB == IE_ADDR)) |
                         (w_wr_byte & (MAB[15:1] == IE_ADDR[15:1]) & MAB[0]);
    assign w_ifg_we[0] = (w_wr_word & (MAB == IFG_ADDR)) |
                         (w_wr_byte & (MAB[15:1] == IFG_ADDR[15:1]) & ~MAB[0]);
    assign w_ifg_we[1] = (w_wr_word & (MAB == IFG_ADDR)) |
                         (w_wr_byte & (MAB[15:1] == IFG_ADDR[15:1]) & MAB[0]);

    assign w_ack_int = (state_q == ST_REQ_INT) & INTACK;
    assign w_ack_nmi = (state_q == ST_REQ_NMI) & INTACK;

    for (genvar i = 0; i < N_SRC; i++) begin : g_bits
        assign w_sel[i]     = (idx_q == IDX_W'(i));
        assign w_ack_clr[i] = w_sel[i] & w_ack_int;
        assign ie_d[i]      = w_ie_we[i / 8] ? MDBout[i] : ie_q[i];
        // Edge set is applied last so it wins over any clear in the same cycle.
        assign ifg_d[i]     = ((w_ifg_we[i / 8] ? MDBout[i] : ifg_q[i]) & ~w_ack_clr[i])
                              | w_irq_edge[i];
    end

    assign w_sel_ie   = |(ie_q & w_sel);
    assign nmi_pend_d = (nmi_pend_q & ~w_ack_nmi) | w_nmi_edge;

    int_prio_enc #(
        .N (N_SRC)
    ) u_prio (
        .req_i   (ifg_q & ie_q),
        .idx_o   (w_win_idx),
        .valid_o (w_win_vld)
    );

    always_ff @(posedge MCLK) begin
        if (reset) begin
            ie_q       <= '0;
            ifg_q      <= '0;
            nmi_pend_q <= 1'b0;
            irq_prev_q <= '1;
            nmi_prev_q <= 1'b1;
        end else begin
            ie_q       <= ie_d;
            ifg_q      <= ifg_d;
            nmi_pend_q <= nmi_pend_d;
            irq_prev_q <= w_irq_s;
            nmi_prev_q <= w_nmi_s;
        end
    end

    always_ff @(posedge MCLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
        end
    end

    // vec_q is only reloaded on entry to a request state, so it stays frozen.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (nmi_pend_q) begin
                    state_d = ST_REQ_NMI;
                    vec_d   = NMI_VEC;
                end else if (w_win_vld) begin
                    state_d = ST_REQ_INT;
                    idx_d   = w_win_idx;
                    vec_d   = 6'(BASE_VEC) + 6'(w_win_idx);
                end
            end
            ST_REQ_INT: begin
                if (INTACK) begin
                    state_d = ST_GAP;
                end else if (nmi_pend_q) begin
                    state_d = ST_REQ_NMI;
                    vec_d   = NMI_VEC;
                end else if (!w_sel_ie) begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ_NMI: begin
                if (INTACK) begin
                    state_d = ST_GAP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        INT         = (state_q == ST_REQ_INT);
        NMI         = (state_q == ST_REQ_NMI);
        IntAddrLSBs = vec_q;
    end

    always_comb begin
        rdata = '0;
        if (MAB[15:1] == IE_ADDR[15:1]) begin
            rdata = 16'(ie_q);
        end else if (MAB[15:1] == IFG_ADDR[15:1]) begin
            rdata = 16'(ifg_q);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module  : tb_int_ctrl
// Brief   : Directed self-checking bench for int_ctrl (honours INT_CTRL_SYNC_EN).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic        MCLK = 1'b0;
    logic        reset;
    logic [7:0]  irq_in;
    logic        nmi_in;
    logic [15:0] MAB;
    logic [15:0] MDBout;
    logic        MW;
    logic        BW;
    logic        INTACK;
    logic        NMI;
    logic        INT;
    logic [5:0]  IntAddrLSBs;
    logic [15:0] rdata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 MCLK = ~MCLK;

    int_ctrl #(
        .N_SRC    (8),
        .BASE_VEC (48),
        .IE_ADDR  (16'h0000),
        .IFG_ADDR (16'h0002)
    ) dut (
        .MCLK        (MCLK),
        .reset       (reset),
        .irq_in      (irq_in),
        .nmi_in      (nmi_in),
        .MAB         (MAB),
        .MDBout      (MDBout),
        .MW          (MW),
        .BW          (BW),
        .INTACK      (INTACK),
        .NMI         (NMI),
        .INT         (INT),
        .IntAddrLSBs (IntAddrLSBs),
        .rdata       (rdata)
    );

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] data, input logic bw);
        MAB    = addr;
        MDBout = data;
        BW     = bw;
        MW     = 1'b1;
        step();
        MW     = 1'b0;
        BW     = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        MAB = addr;
        #1;
        check_val(tag, rdata, exp);
    endtask

    task automatic pulse_irq(input logic [7:0] mask);
        irq_in = mask;
        step();
        irq_in = '0;
    endtask

    task automatic ack();
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq_in = '0; nmi_in = 1'b0; MAB = 16'h0010;
        MDBout = '0; MW = 1'b0; BW = 1'b0; INTACK = 1'b0;
        repeat (2) step();
        check_val("rst_int", {15'd0, INT}, 16'd0);
        check_val("rst_nmi", {15'd0, NMI}, 16'd0);
        check_val("rst_vec", {10'd0, IntAddrLSBs}, 16'd0);
        rd_check("rst_ie", 16'h0000, 16'h0000);
        rd_check("rst_ifg", 16'h0002, 16'h0000);
        reset = 1'b0;
        repeat (3) step();

        // Flag latches with IE=0, request appears once enabled.
        pulse_irq(8'h08);
        repeat (LAT - 1) step();
        rd_check("t1_ifg", 16'h0002, 16'h0008);
        check_val("t1_int_masked", {15'd0, INT}, 16'd0);
        wr(16'h0000, 16'h0008, 1'b0);
        step();
        check_val("t1_int", {15'd0, INT}, 16'd1);
        check_val("t1_vec", {10'd0, IntAddrLSBs}, 16'd51);
        ack();
        check_val("t1_gap", {15'd0, INT}, 16'd0);
        rd_check("t1_ifg_clr", 16'h0002, 16'h0000);
        repeat (2) step();

        // Two simultaneous sources: higher index first.
        wr(16'h0000, 16'h00FF, 1'b0);
        pulse_irq(8'h42);
        repeat (LAT - 1) step();
        check_val("t2_int", {15'd0, INT}, 16'd1);
        check_val("t2_vec_hi", {10'd0, IntAddrLSBs}, 16'd54);
        ack();
        check_val("t2_gap", {15'd0, INT}, 16'd0);
        step();
        check_val("t2_idle", {15'd0, INT}, 16'd0);
        step();
        check_val("t2_int2", {15'd0, INT}, 16'd1);
        check_val("t2_vec_lo", {10'd0, IntAddrLSBs}, 16'd49);
        ack();
        repeat (2) step();

        // NMI preempts a presented maskable request.
        pulse_irq(8'h04);
        repeat (LAT - 1) step();
        check_val("t3_vec50", {10'd0, IntAddrLSBs}, 16'd50);
        nmi_in = 1'b1;
        step();
        nmi_in = 1'b0;
        repeat (LAT - 1) step();
        check_val("t3_nmi", {15'd0, NMI}, 16'd1);
        check_val("t3_int_off", {15'd0, INT}, 16'd0);
        check_val("t3_vec62", {10'd0, IntAddrLSBs}, 16'd62);
        ack();
        check_val("t3_nmi_gap", {15'd0, NMI}, 16'd0);
        rd_check("t3_ifg_kept", 16'h0002, 16'h0004);
        repeat (2) step();
        check_val("t3_reint", {15'd0, INT}, 16'd1);
        check_val("t3_revec", {10'd0, IntAddrLSBs}, 16'd50);

        // Withdraw by clearing IE bit 2 with a low-byte write.
        wr(16'h0000, 16'h00FB, 1'b1);
        step();
        check_val("t4_withdraw", {15'd0, INT}, 16'd0);
        rd_check("t4_ifg", 16'h0002, 16'h0004);
        rd_check("t4_ie", 16'h0000, 16'h00FB);
        wr(16'h0001, 16'hFF00, 1'b1);
        rd_check("t4_ie_hibyte", 16'h0000, 16'h00FB);
        wr(16'h0002, 16'h0000, 1'b0);
        wr(16'h0000, 16'hFFFF, 1'b0);
        rd_check("t4_ie_unimpl", 16'h0000, 16'h00FF);
        repeat (2) step();
        check_val("t4_quiet", {15'd0, INT}, 16'd0);

        // Acknowledge coinciding with a new edge on the same source.
        pulse_irq(8'h01);
        repeat (LAT - 1) step();
        check_val("t5_vec48", {10'd0, IntAddrLSBs}, 16'd48);
        irq_in = 8'h01;
        repeat (LAT - 2) begin
            step();
            irq_in = '0;
        end
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        irq_in = '0;
        check_val("t5_gap", {15'd0, INT}, 16'd0);
        rd_check("t5_ifg_set", 16'h0002, 16'h0001);
        repeat (2) step();
        check_val("t5_reassert", {15'd0, INT}, 16'd1);
        check_val("t5_vec", {10'd0, IntAddrLSBs}, 16'd48);
        ack();
        rd_check("t5_ifg_clr", 16'h0002, 16'h0000);
        repeat (2) step();

        // Readback, unmapped address, NMI priority over pending maskables.
        wr(16'h0000, 16'h0000, 1'b0);
        wr(16'h0002, 16'h0081, 1'b0);
        rd_check("t6_ifg", 16'h0002, 16'h0081);
        rd_check("t6_unmapped", 16'h0004, 16'h0000);
        step();
        check_val("t6_no_int", {15'd0, INT}, 16'd0);
        nmi_in = 1'b1;
        repeat (LAT - 2) begin
            step();
            nmi_in = 1'b0;
        end
        wr(16'h0000, 16'h00FF, 1'b0);
        nmi_in = 1'b0;
        step();
        check_val("t6_nmi_first", {15'd0, NMI}, 16'd1);
        check_val("t6_nmi_vec", {10'd0, IntAddrLSBs}, 16'd62);
        ack();
        repeat (2) step();
        check_val("t6_int", {15'd0, INT}, 16'd1);
        check_val("t6_vec55", {10'd0, IntAddrLSBs}, 16'd55);

        // Reset while a request is presented.
        reset = 1'b1;
        step();
        check_val("t7_int", {15'd0, INT}, 16'd0);
        check_val("t7_vec", {10'd0, IntAddrLSBs}, 16'd0);
        rd_check("t7_ie", 16'h0000, 16'h0000);
        rd_check("t7_ifg", 16'h0002, 16'h0000);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/int_ctrl.md
# int_ctrl

Interrupt controller that sits between peripheral interrupt lines and the CPU's `NMI`/`INT`/`IntAddrLSBs`/`INTACK` handshake. It latches rising edges into pending flags, masks them with a software-visible enable register, and picks the highest-priority request. It presents one request at a time to the CPU with a frozen vector, and clears the serviced flag on `INTACK`. Its IE/IFG registers are memory-mapped on the CPU bus (`MAB`/`MDBout`/`MW`/`BW`).

## Interface
- `N_SRC`, 8: number of maskable sources, 1..16.
- `BASE_VEC`, 48: vector index of source 0. Source i uses `BASE_VEC+i`; `BASE_VEC+N_SRC-1` must be ≤ 61.
- `IE_ADDR`, 16'h0000: word address of the enable register.
- `IFG_ADDR`, 16'h0002: word address of the flag register.
- `MCLK` in 1: the only clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `irq_in` in N_SRC: peripheral lines, rising-edge triggered.
- `nmi_in` in 1: non-maskable line, rising-edge triggered.
- `MAB` in 16: CPU address bus.
- `MDBout` in 16: CPU write data.
- `MW` in 1: CPU write strobe.
- `BW` in 1: byte access.
- `INTACK` in 1: one-cycle CPU acknowledge of the presented request.
- `NMI` out 1: NMI request to the CPU.
- `INT` out 1: maskable request to the CPU.
- `IntAddrLSBs` out 6: vector index; vector address is 16'hFF80 + 2·index.
- `rdata` out 16: register read data, combinational on `MAB`; 0 when not addressed.

## Operation
- **Edge detect:** `prev` register per line, reset to all ones, so a line held high through reset produces no edge. Edge = line high and `prev` low. On an edge the IFG bit or `nmi_pend` sets at that clock edge.
- **Register writes:**
  - Word write (`MW`, !`BW`) to `IE_ADDR` or `IFG_ADDR` loads bits [N_SRC-1:0].
  - Byte write (`MW`, `BW`) loads the lane selected by `MAB[0]`: 0 = low byte, 1 = high byte, at `addr` or `addr+1`.
  - Unimplemented bits read 0.
- **Priority:** the highest set index of IFG&IE wins. NMI beats all maskable sources.
- **FSM states:**
  - IDLE: if `nmi_pend`, go to REQ_NMI. Otherwise, if IFG&IE ≠ 0, go to REQ_INT and latch `vec = BASE_VEC+winner`.
  - REQ_INT: `INT`=1, `IntAddrLSBs`=`vec` (frozen).
    - If `INTACK`: clear the IFG bit of `vec` and go to GAP.
    - Else if `nmi_pend`: go to REQ_NMI (preempt). The maskable flag stays set.
    - Else if IE bit of `vec` is 0: go to IDLE (withdraw).
  - REQ_NMI: `NMI`=1, `IntAddrLSBs`=62. On `INTACK`: clear `nmi_pend` and go to GAP.
  - GAP: one cycle with all requests low, then IDLE.
- **Simultaneous events:** set has priority over clear for the same flag, whether the clear comes from `INTACK` or a software write. A new edge on the source being acknowledged leaves its flag set.
- **Reset mid-operation:** all state returns to reset values on the next edge; requests drop immediately after that edge.
- **Reset values:** `NMI`=0, `INT`=0, `IntAddrLSBs`=0, IE=0, IFG=0, `nmi_pend`=0, state IDLE. `rdata` is combinational, 0 unless addressed.

## Timing
- All outputs except `rdata` are registered.
- Edge sampled at clock k: flag visible after k. State leaves IDLE at k+1, so `INT`/`NMI` is high after k+1. Latency is 2 cycles from sample to request.
- `INTACK` at edge m: request low after m (GAP). Earliest next request is after m+2.
- `IntAddrLSBs` is stable during any cycle with `INT` or `NMI` high.
- Register write at edge k affects arbitration from the IDLE decision at k+1 onward.

## Configuration
- `INT_CTRL_SYNC_EN`:
  - Defined: `irq_in` and `nmi_in` each pass through a two-flop synchronizer, reset to all ones, before edge detect. Latency becomes 4 cycles.
  - Undefined: lines feed edge detect directly and must be synchronous to `MCLK`.

## Structure
- Package `int_ctrl_pkg` holds:
  - the state enum (IDLE, REQ_INT, REQ_NMI, GAP);
  - `NMI_VEC`=62 and `RESET_VEC`=63;
  - the default address constants.
- One sub-module, `int_prio_enc`: parameterised N-to-index priority encoder that returns the highest set bit plus a valid flag.

## Test plan
- After reset, pulse `irq_in[3]` → IFG=16'h0008; `INT` stays 0 because IE=0. Then word-write IE=16'h0008 → `INT`=1, `IntAddrLSBs`=51. `INTACK` → IFG=0 and `INT` low for the GAP cycle.
- IE=16'h00FF; edges on sources 1 and 6 in the same cycle → vector 54 first, then vector 49 after ack and GAP.
- `INT` presenting vector 50, then `nmi_in` edge, no `INTACK` → `NMI`=1 with vector 62. After NMI ack, vector 50 is re-presented.
- IE bit 2 cleared by a byte write while REQ_INT shows vector 50 → `INT` drops the next cycle with no ack. IFG bit 2 remains set.
- `INTACK` for source 0 in the same cycle as a new `irq_in[0]` edge → IFG[0] stays 1 and the request reasserts after GAP.
- Read `IFG_ADDR` with IFG=16'h0081 → `rdata`=16'h0081; read of an unmapped address → 0. With `INT_CTRL_SYNC_EN`, edge-to-`INT` latency is 4 cycles.
